ofs_fim_emif_avmm_rsp_buf: RTL and testbench
============================================

# ofs_fim_emif_avmm_rsp_buf

Credit-throttled AVMM response buffer between an AFU AVMM master and the EMIF AVMM slave port. Commands pass straight through; read commands are held off until their full burst of response beats has space reserved in a local FIFO. This lets the AFU apply backpressure on read data, which the EMIF port itself cannot accept.

## Interface
Parameters:
- ADDR_WIDTH, 27, AVMM word address width
- DATA_WIDTH, 576, read/write data width
- BURSTCOUNT_WIDTH, 7, burstcount width; legal burstcount 1..2^(BURSTCOUNT_WIDTH-1)
- BYTEENABLE_WIDTH, 72, byteenable width
- RSP_DEPTH, 128, response FIFO depth in beats; power of two, >= 2^(BURSTCOUNT_WIDTH-1)

Ports (CW = $clog2(RSP_DEPTH)+1):
- clk  in  1  single clock for the whole block (the EMIF mem_clk domain)
- rst  in  1  synchronous, active-high reset
- afu_read / afu_write  in  1  AFU command strobes
- afu_address  in  ADDR_WIDTH
- afu_burstcount  in  BURSTCOUNT_WIDTH
- afu_writedata  in  DATA_WIDTH
- afu_byteenable  in  BYTEENABLE_WIDTH
- afu_waitrequest  out  1  command stall to AFU
- afu_rdata  out  DATA_WIDTH  buffered read data
- afu_rvalid  out  1  afu_rdata valid
- afu_rready  in  1  AFU accepts beat when afu_rvalid & afu_rready
- emif_read / emif_write  out  1
- emif_address / emif_burstcount / emif_writedata / emif_byteenable  out  matching widths
- emif_waitrequest  in  1
- emif_readdatavalid  in  1
- emif_readdata  in  DATA_WIDTH
- err  out  2  sticky: [0] FIFO overflow, [1] unexpected readdatavalid

## Operation
- Write path pure combinational pass-through: emif_write = afu_write, data/byteenable/address/burstcount forwarded unchanged.
- Read credit: rd_out (CW bits) counts beats requested from EMIF but not yet returned; fifo_cnt (CW bits) counts beats held. credit_ok = (rd_out + fifo_cnt + afu_burstcount) <= RSP_DEPTH, computed at CW+1 bits with no truncation.
- emif_read = afu_read & credit_ok; afu_waitrequest = emif_waitrequest | (afu_read & ~credit_ok).
- Read accepted when emif_read & ~emif_waitrequest: rd_out += afu_burstcount.
- Each emif_readdatavalid: rd_out -= 1 and beat pushed into FIFO. If rd_out==0 at that edge: rd_out stays 0, err[1] set, beat still pushed if FIFO not full.
- Push while full (fifo_cnt==RSP_DEPTH and no pop that cycle): beat dropped, err[0] set.
- Pop on afu_rvalid & afu_rready; fifo_cnt -= 1. Simultaneous accept, return, push and pop in one cycle all apply; net update to each counter is the sum.
- FIFO order strictly preserved; read/write pointers wrap modulo RSP_DEPTH.
- Read of burstcount 0: forwarded, reserves 0 credits, no error (EMIF behaviour undefined; protocol violation of the AFU).
- err bits clear only on rst.

## Timing
- Commands: 0-cycle combinational path AFU to EMIF.
- emif_readdatavalid at edge N gives afu_rvalid high from cycle N+1 (FIFO previously empty); output data registered.
- Back-to-back pops give one beat per cycle while fifo_cnt > 0.
- Credit released by a pop visible to credit_ok the next cycle.
- Reset: afu_rvalid=0, fifo_cnt=0, rd_out=0, err=0, pointers=0; FIFO contents discarded. Read data returning after a mid-operation reset is treated as unexpected (err[1]). The integration holds rst while EMIF is in reset.

## Configuration
- OFS_EMIF_RSP_BUF_STATS_EN defined: adds outputs stat_rd_bursts (32, out) counting accepted read commands, and stat_stall_cycles (32, out) counting cycles with afu_read & ~credit_ok. Both wrap at 2^32 and are zeroed by rst.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Single read, burstcount 4, EMIF returns 4 beats at cycles 10-13, afu_rready=1 -> afu_rvalid at cycles 11-14 with data in order; rd_out and fifo_cnt back to 0; err=0.
- RSP_DEPTH=128, afu_rready=0, issue two reads of burstcount 64, then a third of burstcount 1 -> first two accepted, third held with afu_waitrequest=1. After one pop it is accepted on the next cycle.
- Write burst of 8 with emif_waitrequest toggling -> EMIF sees identical write/data/byteenable sequence; read credits untouched.
- Simultaneous accept(bc=2) + readdatavalid + pop in one cycle with rd_out=3, fifo_cnt=5 -> rd_out=4, fifo_cnt=5.
- readdatavalid with rd_out=0 -> err=2'b10, beat delivered. Forced push when full -> err[0]=1, fifo_cnt stays RSP_DEPTH.
- Reset asserted mid-burst (rd_out=6, fifo_cnt=3) -> next cycle afu_rvalid=0, counters 0, err 0. With STATS_EN, stat counters also 0.

Source files
------------

// File: rtl/ofs_fim_emif_avmm_rsp_buf.sv
// ofs_fim_emif_avmm_rsp_buf
// Credit-throttled AVMM response buffer between an AFU AVMM master and the
// EMIF AVMM slave. Commands pass straight through. A read is held off until
// its whole burst has space reserved in the local response FIFO, so the AFU
// can backpressure read data even though the EMIF port cannot.
// Optional build macro: OFS_EMIF_RSP_BUF_STATS_EN adds the stat_rd_bursts and
// stat_stall_cycles counter outputs.
module ofs_fim_emif_avmm_rsp_buf #(
   parameter int ADDR_WIDTH       = 27,
   parameter int DATA_WIDTH       = 576,
   parameter int BURSTCOUNT_WIDTH = 7,
   parameter int BYTEENABLE_WIDTH = 72,
   parameter int RSP_DEPTH        = 128
) (
   input  logic                        clk,
   input  logic                        rst,

   input  logic                        afu_read,
   input  logic                        afu_write,
   input  logic [ADDR_WIDTH-1:0]       afu_address,
   input  logic [BURSTCOUNT_WIDTH-1:0] afu_burstcount,
   input  logic [DATA_WIDTH-1:0]       afu_writedata,
   input  logic [BYTEENABLE_WIDTH-1:0] afu_byteenable,
   output logic                        afu_waitrequest,
   output logic [DATA_WIDTH-1:0]       afu_rdata,
   output logic                        afu_rvalid,
   input  logic                        afu_rready,

   output logic                        emif_read,
   output logic                        emif_write,
   output logic [ADDR_WIDTH-1:0]       emif_address,
   output logic [BURSTCOUNT_WIDTH-1:0] emif_burstcount,
   output logic [DATA_WIDTH-1:0]       emif_writedata,
   output logic [BYTEENABLE_WIDTH-1:0] emif_byteenable,
   input  logic                        emif_waitrequest,
   input  logic                        emif_readdatavalid,
   input  logic [DATA_WIDTH-1:0]       emif_readdata,

   output logic [1:0]                  err
`ifdef OFS_EMIF_RSP_BUF_STATS_EN
   ,
   output logic [31:0]                 stat_rd_bursts,
   output logic [31:0]                 stat_stall_cycles
`endif
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_CW  = CW'(RSP_DEPTH);
   localparam logic [CW:0]   DEPTH_CW1 = (CW+1)'(RSP_DEPTH);

   // Credit and FIFO bookkeeping
   logic [CW-1:0]         rd_out_q, rd_out_d;
   logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [1:0]            err_q, err_d;
   logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

   logic [CW:0]           credit_sum;
   logic                  credit_ok;
   logic                  rd_accept;
   logic                  pop;
   logic                  full;
   logic                  push;
   logic                  overflow;
   logic                  rd_unexp;

   // Command pass-through, read gated by available credit
   always_comb begin
      credit_sum      = (CW+1)'(rd_out_q) + (CW+1)'(fifo_cnt_q) + (CW+1)'(afu_burstcount);
      credit_ok       = (credit_sum <= DEPTH_CW1);
      emif_read       = afu_read & credit_ok;
      emif_write      = afu_write;
      emif_address    = afu_address;
      emif_burstcount = afu_burstcount;
      emif_writedata  = afu_writedata;
      emif_byteenable = afu_byteenable;
      afu_waitrequest = emif_waitrequest | (afu_read & ~credit_ok);
      rd_accept       = emif_read & ~emif_waitrequest;
   end

   // Response FIFO head is presented straight from storage
   always_comb begin
      afu_rvalid = (fifo_cnt_q != '0);
      afu_rdata  = mem_q[rd_ptr_q];
      pop        = afu_rvalid & afu_rready;
      full       = (fifo_cnt_q == DEPTH_CW);
      // a pop in the same cycle frees the slot the incoming beat needs
      push       = emif_readdatavalid & (~full | pop);
      overflow   = emif_readdatavalid & full & ~pop;
      rd_unexp   = emif_readdatavalid & (rd_out_q == '0);
      err        = err_q;
   end

   // Next-state for counters, pointers and sticky errors
   always_comb begin
      rd_out_d   = rd_out_q;
      fifo_cnt_d = fifo_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      err_d      = err_q;

      if (rd_accept) begin
         rd_out_d = rd_out_d + CW'(afu_burstcount);
      end
      if (emif_readdatavalid && !rd_unexp) begin
         rd_out_d = rd_out_d - CW'(1);
      end

      if (push) begin
         fifo_cnt_d = fifo_cnt_d + CW'(1);
         wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         fifo_cnt_d = fifo_cnt_d - CW'(1);
         rd_ptr_d   = rd_ptr_q + PW'(1);
      end

      if (overflow) begin
         err_d[0] = 1'b1;
      end
      if (rd_unexp) begin
         err_d[1] = 1'b1;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_out_q   <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= '0;
      end else begin
         rd_out_q   <= rd_out_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
      end
   end

   // FIFO storage write; contents need no reset since fifo_cnt gates validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= emif_readdata;
      end
   end

`ifdef OFS_EMIF_RSP_BUF_STATS_EN
   logic [31:0] stat_rd_bursts_q, stat_rd_bursts_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Statistics next-state; both counters wrap naturally at 2^32
   always_comb begin
      stat_rd_bursts_d  = stat_rd_bursts_q;
      stat_stall_d      = stat_stall_q;
      if (rd_accept) begin
         stat_rd_bursts_d = stat_rd_bursts_q + 32'd1;
      end
      if (afu_read && !credit_ok) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end
      stat_rd_bursts    = stat_rd_bursts_q;
      stat_stall_cycles = stat_stall_q;
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_bursts_q <= '0;
         stat_stall_q     <= '0;
      end else begin
         stat_rd_bursts_q <= stat_rd_bursts_d;
         stat_stall_q     <= stat_stall_d;
      end
   end
`endif

endmodule

// File: tb/tb_ofs_fim_emif_avmm_rsp_buf.sv
// Testbench for ofs_fim_emif_avmm_rsp_buf: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_ofs_fim_emif_avmm_rsp_buf;

   localparam int AW    = 27;
   localparam int DW    = 64;
   localparam int BW    = 7;
   localparam int BEW   = 8;
   localparam int DEPTH = 128;

   logic           clk = 1'b0;
   logic           rst;
   logic           afu_read, afu_write;
   logic [AW-1:0]  afu_address;
   logic [BW-1:0]  afu_burstcount;
   logic [DW-1:0]  afu_writedata;
   logic [BEW-1:0] afu_byteenable;
   logic           afu_waitrequest;
   logic [DW-1:0]  afu_rdata;
   logic           afu_rvalid;
   logic           afu_rready;
   logic           emif_read, emif_write;
   logic [AW-1:0]  emif_address;
   logic [BW-1:0]  emif_burstcount;
   logic [DW-1:0]  emif_writedata;
   logic [BEW-1:0] emif_byteenable;
   logic           emif_waitrequest;
   logic           emif_readdatavalid;
   logic [DW-1:0]  emif_readdata;
   logic [1:0]     err;
`ifdef OFS_EMIF_RSP_BUF_STATS_EN
   logic [31:0]    stat_rd_bursts, stat_stall_cycles;
`endif

   ofs_fim_emif_avmm_rsp_buf #(
      .ADDR_WIDTH       (AW),
      .DATA_WIDTH       (DW),
      .BURSTCOUNT_WIDTH (BW),
      .BYTEENABLE_WIDTH (BEW),
      .RSP_DEPTH        (DEPTH)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .afu_read           (afu_read),
      .afu_write          (afu_write),
      .afu_address        (afu_address),
      .afu_burstcount     (afu_burstcount),
      .afu_writedata      (afu_writedata),
      .afu_byteenable     (afu_byteenable),
      .afu_waitrequest    (afu_waitrequest),
      .afu_rdata          (afu_rdata),
      .afu_rvalid         (afu_rvalid),
      .afu_rready         (afu_rready),
      .emif_read          (emif_read),
      .emif_write         (emif_write),
      .emif_address       (emif_address),
      .emif_burstcount    (emif_burstcount),
      .emif_writedata     (emif_writedata),
      .emif_byteenable    (emif_byteenable),
      .emif_waitrequest   (emif_waitrequest),
      .emif_readdatavalid (emif_readdatavalid),
      .emif_readdata      (emif_readdata),
      .err                (err)
`ifdef OFS_EMIF_RSP_BUF_STATS_EN
      ,
      .stat_rd_bursts     (stat_rd_bursts),
      .stat_stall_cycles  (stat_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: outstanding beat count, queue of held beats, sticky errors
   int          m_out = 0;
   logic [DW-1:0] exp_q[$];
   logic [1:0]  m_err = 2'b00;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom(), $urandom()};
   endfunction

   // One clock: check outputs for the current inputs, then advance the model
   task automatic tick();
      int            n;
      bit            cr, acc, pop, rdv, rs;
      int            bcv;
      logic [DW-1:0] d;
      #1;
      n   = exp_q.size();
      bcv = int'(afu_burstcount);
      cr  = (m_out + n + bcv) <= DEPTH;
      chk("emif_read",   emif_read, afu_read & cr);
      chk("afu_waitreq", afu_waitrequest, emif_waitrequest | (afu_read & !cr));
      chk("afu_rvalid",  afu_rvalid, n != 0);
      if (n != 0) chk("afu_rdata", afu_rdata, exp_q[0]);
      chk("err",         err, m_err);
      chk("emif_write",  emif_write, afu_write);
      chk("emif_addr",   emif_address, afu_address);
      chk("emif_bc",     emif_burstcount, afu_burstcount);
      chk("emif_wdata",  emif_writedata, afu_writedata);
      chk("emif_be",     emif_byteenable, afu_byteenable);
      acc = afu_read && cr && !emif_waitrequest;
      pop = (n != 0) && afu_rready;
      rdv = emif_readdatavalid;
      d   = emif_readdata;
      rs  = rst;
      @(posedge clk);
      #1;
      if (rs) begin
         m_out = 0;
         exp_q.delete();
         m_err = 2'b00;
      end else begin
         if (rdv) begin
            if (m_out == 0) m_err[1] = 1'b1;
            else m_out--;
         end
         if (acc) m_out += bcv;
         if (pop) void'(exp_q.pop_front());
         if (rdv) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else m_err[0] = 1'b1;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rdv_beats(input int n);
      emif_readdatavalid = 1'b1;
      for (int i = 0; i < n; i++) begin
         emif_readdata = rnd_data();
         tick();
      end
      emif_readdatavalid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      afu_read = 0; afu_write = 0; afu_address = '0; afu_burstcount = '0;
      afu_writedata = '0; afu_byteenable = '0; afu_rready = 0;
      emif_waitrequest = 0; emif_readdatavalid = 0; emif_readdata = '0;
      @(posedge clk);
      #1;
      ticks(2);
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_rvalid", afu_rvalid, 0);
      chk("rst_err",    err, 0);
      chk("rst_rd_out", dut.rd_out_q, 0);
      chk("rst_fifo",   dut.fifo_cnt_q, 0);
`ifdef OFS_EMIF_RSP_BUF_STATS_EN
      chk("rst_stat_b", stat_rd_bursts, 0);
      chk("rst_stat_s", stat_stall_cycles, 0);
`endif

      // Single read of 4 beats, returned and consumed immediately
      afu_rready = 1; afu_read = 1; afu_burstcount = 7'd4; afu_address = 27'h123456;
      tick();
      afu_read = 0;
      ticks(5);
      rdv_beats(4);
      ticks(3);
      chk("single_rd_out", dut.rd_out_q, 0);
      chk("single_fifo",   dut.fifo_cnt_q, 0);
      chk("single_err",    err, 0);

      // Unexpected readdatavalid: flagged but still delivered
      afu_rready = 0;
      rdv_beats(1);
      chk("unexp_err", err, 2'b10);
      chk("unexp_rvalid", afu_rvalid, 1);
      afu_rready = 1;
      ticks(2);
      do_reset();

      // Credit exhaustion at exactly DEPTH beats reserved
      afu_rready = 0; afu_read = 1; afu_burstcount = 7'd64;
      ticks(2);
      afu_burstcount = 7'd1;
      tick();
      chk("credit_hold", afu_waitrequest, 1);
      rdv_beats(DEPTH);
      afu_rready = 1;
      tick();
      afu_rready = 0;
      #1;
      chk("credit_release", emif_read, 1);
      tick();
      afu_read = 0;
      rdv_beats(1);
      chk("full_cnt", dut.fifo_cnt_q, DEPTH);
      rdv_beats(1);
      chk("overflow_err", err, 2'b11);
      chk("overflow_cnt", dut.fifo_cnt_q, DEPTH);
      afu_rready = 1;
      ticks(DEPTH + 2);
      do_reset();

      // Write burst with toggling waitrequest: pure pass-through
      afu_burstcount = 7'd8;
      for (int i = 0; i < 8; i++) begin
         afu_write = 1; afu_address = 27'($urandom());
         afu_writedata = rnd_data(); afu_byteenable = 8'($urandom());
         emif_waitrequest = i[0];
         tick();
      end
      afu_write = 0; emif_waitrequest = 0;
      tick();
      chk("wr_rd_out", dut.rd_out_q, 0);
      chk("wr_fifo",   dut.fifo_cnt_q, 0);

      // Simultaneous accept + return + pop
      afu_rready = 0; afu_read = 1; afu_burstcount = 7'd8;
      tick();
      afu_read = 0;
      rdv_beats(5);
      chk("sim_pre_rd_out", dut.rd_out_q, 3);
      chk("sim_pre_fifo",   dut.fifo_cnt_q, 5);
      afu_read = 1; afu_burstcount = 7'd2; afu_rready = 1;
      rdv_beats(1);
      afu_read = 0; afu_rready = 0;
      chk("sim_rd_out", dut.rd_out_q, 4);
      chk("sim_fifo",   dut.fifo_cnt_q, 5);
      afu_rready = 1;
      rdv_beats(4);
      ticks(10);

      // Reset in the middle of a burst
      afu_rready = 0; afu_read = 1; afu_burstcount = 7'd9;
      tick();
      afu_read = 0;
      rdv_beats(3);
      chk("mid_rd_out", dut.rd_out_q, 6);
      chk("mid_fifo",   dut.fifo_cnt_q, 3);
      do_reset();
      chk("mid_rvalid",  afu_rvalid, 0);
      chk("mid_err",     err, 0);
      chk("mid_rd_out0", dut.rd_out_q, 0);
      chk("mid_fifo0",   dut.fifo_cnt_q, 0);
`ifdef OFS_EMIF_RSP_BUF_STATS_EN
      chk("mid_stat_b", stat_rd_bursts, 0);
      chk("mid_stat_s", stat_stall_cycles, 0);
`endif
      rdv_beats(1);
      chk("post_rst_unexp", err, 2'b10);
      afu_rready = 1;
      ticks(2);
      do_reset();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int op;
         op = $urandom_range(0, 3);
         afu_read  = (op == 1);
         afu_write = (op == 2);
         afu_burstcount = ($urandom_range(0, 31) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
         afu_address    = 27'($urandom());
         afu_writedata  = rnd_data();
         afu_byteenable = 8'($urandom());
         emif_waitrequest   = ($urandom_range(0, 3) == 0);
         emif_readdatavalid = (m_out > 0) && ($urandom_range(0, 2) != 0);
         emif_readdata      = rnd_data();
         afu_rready         = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Drain everything still outstanding or held, with a fixed budget
      afu_read = 0; afu_write = 0; emif_waitrequest = 0; afu_rready = 1;
      for (int c = 0; c < 400 && (m_out > 0 || exp_q.size() > 0); c++) begin
         emif_readdatavalid = (m_out > 0);
         emif_readdata      = rnd_data();
         tick();
      end
      emif_readdatavalid = 0;
      tick();
      chk("drain_rd_out", dut.rd_out_q, 0);
      chk("drain_fifo",   dut.fifo_cnt_q, 0);
      chk("drain_rvalid", afu_rvalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
